hazard_unit: RTL and testbench

- Feedback counterpart to the pipelined controller. The controller pushes control forward D->E->M->W; this block sends stall, flush and forwarding selects back to the earlier stages.
- It tracks its own copy of source and destination register numbers and write-enables through E/M/W, so it needs only D-stage inputs plus the E-stage condition result.
- It also keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_unit_pkg.sv | 17 +
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hazard_stage_reg.sv | 30 +++
 rtl/hazard_unit.sv | 84 ++++++++
 tb/tb_hazard_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: constants and helpers shared by the hazard unit files.
//   FWD_* : operand forward-select encodings for ForwardAE/ForwardBE.
//   fwd_sel(): priority encoder for the forward-select outputs.
package hazard_unit_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // The M-stage result is newer than the W-stage result, so it wins.
   function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
      if (hit_m)      return FWD_MEM;
      else if (hit_w) return FWD_WB;
      else            return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: groups the D-stage/E-stage inputs and the hazard outputs.
//   master : the pipeline side, drives D-stage fields, CondExE, BranchTakenE.
//   slave  : the hazard unit, drives stall/flush/forward/StallCount.
interface hazard_unit_if #(
   parameter int REGW = 4,
   parameter int CNTW = 16
);
   logic [REGW-1:0] RA1D;
   logic [REGW-1:0] RA2D;
   logic [REGW-1:0] WA3D;
   logic            RegWriteD;
   logic            MemtoRegD;
   logic            PCSrcD;
   logic            CondExE;
   logic            BranchTakenE;
   logic            StallF;
   logic            StallD;
   logic            FlushD;
   logic            FlushE;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [CNTW-1:0] StallCount;

   modport master (
      output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount
   );

   modport slave (
      input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount
   );
endinterface

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline-tracking register of the hazard unit.
//   clk, rst_n : clock, async active-low reset (clears to a bubble)
//   bubble_i   : synchronous bubble, clears the EN_MASK bits on load
//   d_i / q_o  : packed stage fields in / out
module hazard_stage_reg #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   EN_MASK = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Register-number fields still load during a bubble; only the enables matter.
   always_comb begin
      q_d = d_i;
      if (bubble_i) q_d = d_i & ~EN_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and operand-forwarding control for a D/E/M/W pipeline.
//   clk   : system clock
//   reset : async active-low reset, pipeline tracking becomes all bubbles
//   hz    : slave side of hazard_unit_if (D-stage fields, CondExE,
//           BranchTakenE in; StallF/D, FlushD/E, ForwardAE/BE, StallCount out)
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REGW = 4,
   parameter int CNTW = 16
) (
   input  logic          clk,
   input  logic          reset,
   hazard_unit_if.slave  hz
);
   localparam int EW = 3*REGW + 3;
   localparam int MW = REGW + 2;
   localparam logic [EW-1:0] E_EN_MASK = {{(3*REGW){1'b0}}, 3'b111};

   logic [EW-1:0]   e_d, e_q;
   logic [MW-1:0]   m_d, m_q;
   logic [MW-1:0]   w_q;
   logic [REGW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
   logic            regw_e, memtoreg_e, pcsrc_e;
   logic            regw_m, pcsrc_m, regw_w, pcsrc_w;
   logic            ldr_stall, pc_wr_pending, flush_e;
   logic [CNTW-1:0] cnt_q, cnt_d;

   assign e_d = {hz.RA1D, hz.RA2D, hz.WA3D, hz.RegWriteD, hz.MemtoRegD, hz.PCSrcD};

   hazard_stage_reg #(.W(EW), .EN_MASK(E_EN_MASK)) u_stage_e (
      .clk(clk), .rst_n(reset), .bubble_i(flush_e), .d_i(e_d), .q_o(e_q)
   );

   assign ra1_e      = e_q[EW-1 -: REGW];
   assign ra2_e      = e_q[EW-1-REGW -: REGW];
   assign wa3_e      = e_q[3 +: REGW];
   assign regw_e     = e_q[2];
   assign memtoreg_e = e_q[1];
   assign pcsrc_e    = e_q[0];

   // The load flag stops at E: no hazard decision past E looks at it.
   assign m_d = {wa3_e, regw_e & hz.CondExE, pcsrc_e & hz.CondExE};

   hazard_stage_reg #(.W(MW)) u_stage_m (
      .clk(clk), .rst_n(reset), .bubble_i(1'b0), .d_i(m_d), .q_o(m_q)
   );

   hazard_stage_reg #(.W(MW)) u_stage_w (
      .clk(clk), .rst_n(reset), .bubble_i(1'b0), .d_i(m_q), .q_o(w_q)
   );

   assign wa3_m   = m_q[2 +: REGW];
   assign regw_m  = m_q[1];
   assign pcsrc_m = m_q[0];
   assign wa3_w   = w_q[2 +: REGW];
   assign regw_w  = w_q[1];
   assign pcsrc_w = w_q[0];

   assign ldr_stall     = memtoreg_e & regw_e & ((hz.RA1D == wa3_e) | (hz.RA2D == wa3_e));
   assign pc_wr_pending = hz.PCSrcD | pcsrc_e | pcsrc_m;
   assign flush_e       = ldr_stall | hz.BranchTakenE;

   assign hz.StallF    = ldr_stall | pc_wr_pending;
   assign hz.StallD    = ldr_stall;
   assign hz.FlushD    = pc_wr_pending | pcsrc_w | hz.BranchTakenE;
   assign hz.FlushE    = flush_e;
   assign hz.ForwardAE = fwd_sel(regw_m & (ra1_e == wa3_m), regw_w & (ra1_e == wa3_w));
   assign hz.ForwardBE = fwd_sel(regw_m & (ra2_e == wa3_m), regw_w & (ra2_e == wa3_w));

   // Saturating stall-cycle counter; holds at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (ldr_stall && (cnt_q != {CNTW{1'b1}}))
         cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign hz.StallCount = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hazard_unit_if #(.REGW(4), .CNTW(16)) hif ();
   hazard_unit_if #(.REGW(4), .CNTW(2))  sif ();

   hazard_unit #(.REGW(4), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .hz(hif)
   );

   hazard_unit #(.REGW(4), .CNTW(2)) dut_sat (
      .clk(clk), .reset(reset), .hz(sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                        input logic rw, input logic mr, input logic pc);
      hif.RA1D      = ra1;
      hif.RA2D      = ra2;
      hif.WA3D      = wa3;
      hif.RegWriteD = rw;
      hif.MemtoRegD = mr;
      hif.PCSrcD    = pc;
   endtask

   task automatic idle(input int n);
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      hif.BranchTakenE = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stallF"}, {31'd0, hif.StallF}, 32'd0);
      chk({tag, "_stallD"}, {31'd0, hif.StallD}, 32'd0);
      chk({tag, "_flushD"}, {31'd0, hif.FlushD}, 32'd0);
      chk({tag, "_flushE"}, {31'd0, hif.FlushE}, 32'd0);
      chk({tag, "_fwdA"},   {30'd0, hif.ForwardAE}, 32'd0);
      chk({tag, "_fwdB"},   {30'd0, hif.ForwardBE}, 32'd0);
      chk({tag, "_count"},  {16'd0, hif.StallCount}, 32'd0);
   endtask

   logic [4:0] exp_sf;
   logic [4:0] exp_fd;
   int         sat_exp [5];

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      hif.CondExE = 1'b0;
      hif.BranchTakenE = 1'b0;
      sif.RA1D = '0; sif.RA2D = '0; sif.WA3D = '0;
      sif.RegWriteD = 1'b0; sif.MemtoRegD = 1'b0; sif.PCSrcD = 1'b0;
      sif.CondExE = 1'b0; sif.BranchTakenE = 1'b0;

      // Random activity while reset is held must leave no state behind
      for (int i = 0; i < 6; i++) begin
         set_d(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         hif.CondExE = 1'($urandom);
         tick();
      end
      idle(0);
      hif.CondExE = 1'b0;
      #1;
      chk_all_zero("reset_held");
      tick();
      reset = 1'b1;
      #1;
      chk_all_zero("reset_rel");
      idle(2);

      // Forward from M, then from W
      hif.CondExE = 1'b1;
      set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
      tick();
      set_d(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      set_d(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fwdA_mem", {30'd0, hif.ForwardAE}, 32'd2);
      chk("fwdB_idle", {30'd0, hif.ForwardBE}, 32'd0);
      tick();
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fwdB_wb", {30'd0, hif.ForwardBE}, 32'd1);
      chk("fwdA_none", {30'd0, hif.ForwardAE}, 32'd0);
      idle(3);

      // Condition fails while the writer is in E
      set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
      tick();
      hif.CondExE = 1'b0;
      set_d(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      hif.CondExE = 1'b1;
      set_d(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("condfail_fwdA", {30'd0, hif.ForwardAE}, 32'd0);
      tick();
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("condfail_fwdB", {30'd0, hif.ForwardBE}, 32'd0);
      idle(3);

      // Load-use: one stall cycle, then forward from W
      set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
      #1;
      chk("ld_nostall", {31'd0, hif.StallD}, 32'd0);
      tick();
      set_d(4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("ld_stallF", {31'd0, hif.StallF}, 32'd1);
      chk("ld_stallD", {31'd0, hif.StallD}, 32'd1);
      chk("ld_flushE", {31'd0, hif.FlushE}, 32'd1);
      chk("ld_flushD", {31'd0, hif.FlushD}, 32'd0);
      chk("ld_cnt0", {16'd0, hif.StallCount}, 32'd0);
      tick();
      #1;
      chk("ld_stall_end", {31'd0, hif.StallD}, 32'd0);
      chk("ld_flushE_end", {31'd0, hif.FlushE}, 32'd0);
      chk("ld_cnt1", {16'd0, hif.StallCount}, 32'd1);
      tick();
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("ld_fwdB_wb", {30'd0, hif.ForwardBE}, 32'd1);
      chk("ld_cnt_hold", {16'd0, hif.StallCount}, 32'd1);
      idle(3);

      // Branch taken flushes D and E, E then carries a bubble
      set_d(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
      tick();
      set_d(4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
      hif.BranchTakenE = 1'b1;
      #1;
      chk("br_flushD", {31'd0, hif.FlushD}, 32'd1);
      chk("br_flushE", {31'd0, hif.FlushE}, 32'd1);
      chk("br_stallD", {31'd0, hif.StallD}, 32'd0);
      tick();
      hif.BranchTakenE = 1'b0;
      set_d(4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("br_flushD_end", {31'd0, hif.FlushD}, 32'd0);
      chk("br_flushE_end", {31'd0, hif.FlushE}, 32'd0);
      tick();
      set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("br_bubble_nofwd", {30'd0, hif.ForwardAE}, 32'd0);
      idle(3);

      // PC write, condition passes then fails
      for (int c = 1; c >= 0; c--) begin
         if (c == 1) begin exp_sf = 5'b00111; exp_fd = 5'b01111; end
         else        begin exp_sf = 5'b00011; exp_fd = 5'b00011; end
         hif.CondExE = c[0];
         set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
         for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("pc%0d_stallF_%0d", c, k), {31'd0, hif.StallF}, {31'd0, exp_sf[k]});
            chk($sformatf("pc%0d_flushD_%0d", c, k), {31'd0, hif.FlushD}, {31'd0, exp_fd[k]});
            tick();
            set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
         end
         idle(2);
      end
      hif.CondExE = 1'b1;

      // Asynchronous reset in the middle of a load-use stall
      set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
      tick();
      set_d(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("ar_stall_before", {31'd0, hif.StallD}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_stallD", {31'd0, hif.StallD}, 32'd0);
      chk("ar_stallF", {31'd0, hif.StallF}, 32'd0);
      chk("ar_flushE", {31'd0, hif.FlushE}, 32'd0);
      chk("ar_count", {16'd0, hif.StallCount}, 32'd0);
      tick();
      reset = 1'b1;
      idle(2);

      // Saturation with a 2-bit counter: stalls recur every other cycle
      sat_exp = '{1, 2, 3, 3, 3};
      sif.RA1D = 4'd5; sif.WA3D = 4'd5;
      sif.RegWriteD = 1'b1; sif.MemtoRegD = 1'b1; sif.CondExE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("sat_stall_%0d", i), {31'd0, sif.StallD}, 32'd1);
         tick();
         chk($sformatf("sat_cnt_%0d", i), {30'd0, sif.StallCount}, sat_exp[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
